ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline. Consumes the decoded op from the ID/EX register and

---
 rtl/ex_pkg.sv | 43 ++++
 rtl/ex_stage_mul_iter.sv | 89 ++++++++
 rtl/ex_stage.sv | 148 ++++++++++++++
 tb/tb_ex_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage.
// Holds op/select codes, bus widths, the multiplier state encoding and a magnitude helper.
package ex_pkg;

  localparam int REG_W    = 32;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;
  localparam int GPR_W    = 5;

  localparam logic [ALUOP_W-1:0] ALU_NOP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] ALU_NOR   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] ALU_SLL   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] ALU_SRL   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] ALU_SRA   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] ALU_MOVZ  = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] ALU_MOVN  = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] ALU_MFHI  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] ALU_MTHI  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] ALU_MFLO  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] ALU_MTLO  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] ALU_MULT  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] ALU_MULTU = 8'b0001_1001;

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] SEL_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned |-2^31|.
  function automatic logic [REG_W-1:0] abs32(input logic [REG_W-1:0] x);
    return x[REG_W-1] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add magnitude multiplier: STEP_BITS multiplier bits retired per BUSY cycle.
// Operands are latched on start; abort drops back to IDLE without ever reaching DONE.
module mul_iter
  import ex_pkg::*;
#(
  parameter int STEP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_W-1:0]     a,
  input  logic [REG_W-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*REG_W-1:0]   prod
);

  localparam logic [4:0] LAST_CNT = 5'(32 / STEP_BITS - 1);

  mul_state_e          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2*REG_W-1:0]  mcand_q, mcand_d;
  logic [2*REG_W-1:0]  acc_q, acc_d;
  logic [REG_W-1:0]    mplr_q, mplr_d;
  logic [2*REG_W-1:0]  step_sum;

  always_comb begin
    step_sum = acc_q;
    for (int k = 0; k < STEP_BITS; k++) begin
      if (mplr_q[k]) step_sum = step_sum + (mcand_q << k);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d = MUL_BUSY;
          cnt_d   = '0;
          mcand_d = {32'd0, a};
          mplr_d  = b;
          acc_d   = '0;
        end
      end
      MUL_BUSY: begin
        acc_d   = step_sum;
        mcand_d = mcand_q << STEP_BITS;
        mplr_d  = mplr_q >> STEP_BITS;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = MUL_DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
    if (abort) begin
      state_d = MUL_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
    end
  end

  assign busy = (state_q == MUL_BUSY);
  assign done = (state_q == MUL_DONE);
  assign prod = acc_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift/move result mux, HI/LO registers, multiply control
// and the EX/MEM pipeline register, plus same-cycle forwarding back to decode.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [REG_W-1:0]    reg1_i,
  input  logic [REG_W-1:0]    reg2_i,
  input  logic [GPR_W-1:0]    wd_i,
  input  logic                wreg_i,
  input  logic                flush_i,
  output logic                ex_wreg_o,
  output logic [GPR_W-1:0]    ex_wd_o,
  output logic [REG_W-1:0]    ex_wdata_o,
  output logic                mem_wreg_o,
  output logic [GPR_W-1:0]    mem_wd_o,
  output logic [REG_W-1:0]    mem_wdata_o,
  output logic [REG_W-1:0]    hi_o,
  output logic [REG_W-1:0]    lo_o,
  output logic                stallreq_o
);

  logic                mem_wreg_q, mem_wreg_d;
  logic [GPR_W-1:0]    mem_wd_q, mem_wd_d;
  logic [REG_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [REG_W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                sign_q, sign_d;
  logic [REG_W-1:0]    result;
  logic                is_move, is_mult, is_signed_mult;
  logic                mul_start, mul_busy, mul_done;
  logic [REG_W-1:0]    mul_a, mul_b;
  logic [2*REG_W-1:0]  mul_prod, prod_signed;

  assign is_move        = aluop_i inside {ALU_MFHI, ALU_MFLO, ALU_MOVN, ALU_MOVZ};
  assign is_signed_mult = (aluop_i == ALU_MULT);
  assign is_mult        = is_signed_mult || (aluop_i == ALU_MULTU);

  always_comb begin
    result = '0;
    if (is_move) begin
      case (aluop_i)
        ALU_MFHI: result = hi_q;
        ALU_MFLO: result = lo_q;
        default:  result = reg1_i;
      endcase
    end else begin
      case (alusel_i)
        SEL_LOGIC: begin
          case (aluop_i)
            ALU_OR:  result = reg1_i | reg2_i;
            ALU_AND: result = reg1_i & reg2_i;
            ALU_XOR: result = reg1_i ^ reg2_i;
            ALU_NOR: result = ~(reg1_i | reg2_i);
            default: result = '0;
          endcase
        end
        SEL_SHIFT: begin
          case (aluop_i)
            ALU_SLL: result = reg2_i << reg1_i[4:0];
            ALU_SRL: result = reg2_i >> reg1_i[4:0];
            ALU_SRA: result = 32'($signed(reg2_i) >>> reg1_i[4:0]);
            default: result = '0;
          endcase
        end
        default: result = '0;
      endcase
    end
  end

  // The multiplier only sees magnitudes; the sign is re-applied when the product lands in HI/LO.
  assign mul_a     = is_signed_mult ? abs32(reg1_i) : reg1_i;
  assign mul_b     = is_signed_mult ? abs32(reg2_i) : reg2_i;
  assign mul_start = is_mult && !mul_busy && !mul_done && !flush_i;

  mul_iter #(
    .STEP_BITS (MUL_STEP_BITS)
  ) u_mul_iter (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .abort (flush_i),
    .a     (mul_a),
    .b     (mul_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign prod_signed = sign_q ? (~mul_prod + 64'd1) : mul_prod;
  assign stallreq_o  = mul_start || (mul_busy && !flush_i);

  always_comb begin
    sign_d = sign_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (mul_start) sign_d = is_signed_mult && (reg1_i[31] ^ reg2_i[31]);
    if (!flush_i) begin
      if (mul_done) begin
        {hi_d, lo_d} = prod_signed;
      end else if (aluop_i == ALU_MTHI) begin
        hi_d = reg1_i;
      end else if (aluop_i == ALU_MTLO) begin
        lo_d = reg1_i;
      end
    end
  end

  // Stall cycles and the DONE cycle send a bubble to MEM; the multiply never writes a GPR.
  always_comb begin
    mem_wreg_d  = wreg_i;
    mem_wd_d    = wd_i;
    mem_wdata_d = result;
    if (flush_i || stallreq_o || mul_done) mem_wreg_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wreg_q  <= 1'b0;
      mem_wd_q    <= '0;
      mem_wdata_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      sign_q      <= 1'b0;
    end else begin
      mem_wreg_q  <= mem_wreg_d;
      mem_wd_q    <= mem_wd_d;
      mem_wdata_q <= mem_wdata_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      sign_q      <= sign_d;
    end
  end

  assign ex_wreg_o   = wreg_i;
  assign ex_wd_o     = wd_i;
  assign ex_wdata_o  = result;
  assign mem_wreg_o  = mem_wreg_q;
  assign mem_wd_o    = mem_wd_q;
  assign mem_wdata_o = mem_wdata_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU ops and multiplies
// compared against a behavioural model of results and of the HI/LO registers.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int STEP = 1;
  localparam int STALL_CYCLES = 1 + 32 / STEP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = '0;
  logic [2:0]  alusel_i = '0;
  logic [31:0] reg1_i = '0, reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ex_wreg_o, mem_wreg_o, stallreq_o;
  logic [4:0]  ex_wd_o, mem_wd_o;
  logic [31:0] ex_wdata_o, mem_wdata_o, hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0, mlo = '0;
  logic [7:0]  pool [11] = '{ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA,
                             ALU_MOVZ, ALU_MOVN, ALU_MFHI, ALU_MFLO};

  ex_stage #(.MUL_STEP_BITS(STEP)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
    .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o),
    .mem_wreg_o(mem_wreg_o), .mem_wd_o(mem_wd_o), .mem_wdata_o(mem_wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Expected GPR result straight from the instruction semantics.
  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [2:0] sel,
                                             input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = int'(a % 32);
    if (op == ALU_MFHI) return mhi;
    if (op == ALU_MFLO) return mlo;
    if (op == ALU_MOVN || op == ALU_MOVZ) return a;
    if (sel == SEL_LOGIC) begin
      if (op == ALU_OR)  return a | b;
      if (op == ALU_AND) return a & b;
      if (op == ALU_XOR) return a ^ b;
      if (op == ALU_NOR) return ~(a | b);
    end
    if (sel == SEL_SHIFT) begin
      if (op == ALU_SLL) return 32'(64'(b) * (64'd1 << sh));
      if (op == ALU_SRL) return b / (32'd1 << sh);
      if (op == ALU_SRA) begin
        r = b / (32'd1 << sh);
        if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
        return r;
      end
    end
    return 32'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wr);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
  endtask

  task automatic drive_nop;
    drive(ALU_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(ALU_OR, SEL_LOGIC, 32'h0000_A5A5, 32'h5A00_0000, 5'd7, 1'b1);
    tick; tick;
    checks++; if (mem_wreg_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_wreg got=%b exp=0", mem_wreg_o); end
    checks++; if (mem_wd_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_mem_wd got=%0d exp=0", mem_wd_o); end
    checks++; if (mem_wdata_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", mem_wdata_o); end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_hilo got=%h_%h exp=0", hi_o, lo_o); end
    checks++; if (stallreq_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", stallreq_o); end
    rst = 1'b0;
    mhi = '0; mlo = '0;
    drive_nop;
    tick;
  endtask

  task automatic test_or;
    drive(ALU_OR, SEL_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
    #1;
    checks++; if (ex_wdata_o !== 32'h0000_FFFF) begin failures++; $display("[TB] FAIL or_ex_wdata got=%h exp=0000ffff", ex_wdata_o); end
    checks++; if (ex_wd_o !== 5'd5 || ex_wreg_o !== 1'b1) begin failures++; $display("[TB] FAIL or_ex_fwd got=%0d/%b exp=5/1", ex_wd_o, ex_wreg_o); end
    tick;
    checks++; if (mem_wd_o !== 5'd5 || mem_wreg_o !== 1'b1) begin failures++; $display("[TB] FAIL or_mem_wd got=%0d/%b exp=5/1", mem_wd_o, mem_wreg_o); end
    checks++; if (mem_wdata_o !== 32'h0000_FFFF) begin failures++; $display("[TB] FAIL or_mem_wdata got=%h exp=0000ffff", mem_wdata_o); end
  endtask

  task automatic test_shift;
    drive(ALU_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd6, 1'b1);
    #1;
    checks++; if (ex_wdata_o !== 32'hF800_0001) begin failures++; $display("[TB] FAIL sra got=%h exp=f8000001", ex_wdata_o); end
    tick;
    checks++; if (mem_wdata_o !== 32'hF800_0001) begin failures++; $display("[TB] FAIL sra_mem got=%h exp=f8000001", mem_wdata_o); end
    drive(ALU_SRL, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd6, 1'b1);
    #1;
    checks++; if (ex_wdata_o !== 32'h0800_0001) begin failures++; $display("[TB] FAIL srl got=%h exp=08000001", ex_wdata_o); end
    tick;
  endtask

  task automatic test_random_alu(input int n);
    logic [7:0] op; logic [2:0] sel; logic [31:0] a, b, exp; logic [4:0] wd; logic wr;
    for (int i = 0; i < n; i++) begin
      op = pool[$urandom_range(0, 10)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 1) == 1) a = a % 40;
      wd = 5'($urandom); wr = 1'($urandom);
      if (op inside {ALU_OR, ALU_AND, ALU_XOR, ALU_NOR}) sel = SEL_LOGIC;
      else if (op inside {ALU_SLL, ALU_SRL, ALU_SRA}) sel = SEL_SHIFT;
      else sel = SEL_MOVE;
      if ($urandom_range(0, 5) == 0) sel = 3'($urandom);
      drive(op, sel, a, b, wd, wr);
      exp = ref_result(op, sel, a, b);
      #1;
      checks++; if (ex_wdata_o !== exp) begin failures++; $display("[TB] FAIL rand_ex_wdata op=%h sel=%0d got=%h exp=%h", op, sel, ex_wdata_o, exp); end
      checks++; if (ex_wreg_o !== wr || ex_wd_o !== wd) begin failures++; $display("[TB] FAIL rand_ex_fwd got=%b/%0d exp=%b/%0d", ex_wreg_o, ex_wd_o, wr, wd); end
      tick;
      checks++; if (mem_wdata_o !== exp || mem_wreg_o !== wr || mem_wd_o !== wd) begin
        failures++; $display("[TB] FAIL rand_mem got=%h/%b/%0d exp=%h/%b/%0d", mem_wdata_o, mem_wreg_o, mem_wd_o, exp, wr, wd);
      end
    end
    drive_nop;
  endtask

  task automatic test_hilo;
    logic [31:0] v;
    drive(ALU_MTHI, SEL_NOP, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
    tick; mhi = 32'h1234_5678;
    drive(ALU_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd3, 1'b1);
    #1;
    checks++; if (ex_wdata_o !== 32'h1234_5678) begin failures++; $display("[TB] FAIL mfhi got=%h exp=12345678", ex_wdata_o); end
    checks++; if (hi_o !== 32'h1234_5678) begin failures++; $display("[TB] FAIL mthi_hi got=%h exp=12345678", hi_o); end
    tick;
    v = $urandom;
    drive(ALU_MTLO, SEL_NOP, v, 32'd0, 5'd0, 1'b0);
    tick; mlo = v;
    drive(ALU_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    #1;
    checks++; if (ex_wdata_o !== v || lo_o !== v) begin failures++; $display("[TB] FAIL mflo got=%h/%h exp=%h", ex_wdata_o, lo_o, v); end
    checks++; if (hi_o !== mhi) begin failures++; $display("[TB] FAIL mtlo_kept_hi got=%h exp=%h", hi_o, mhi); end
    tick;
    drive_nop;
  endtask

  task automatic run_mult(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int cnt, bad;
    if (op == ALU_MULTU) exp = 64'(a) * 64'(b);
    else exp = 64'(longint'($signed(a)) * longint'($signed(b)));
    cnt = 0; bad = 0;
    drive(op, SEL_NOP, a, b, 5'd9, 1'b1);
    #1;
    while (stallreq_o === 1'b1 && cnt < 200) begin
      cnt++;
      tick;
      if (mem_wreg_o !== 1'b0) bad++;
    end
    checks++; if (cnt != STALL_CYCLES) begin failures++; $display("[TB] FAIL mult_stall_len got=%0d exp=%0d", cnt, STALL_CYCLES); end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL mult_bubble got=%0d exp=0 writes", bad); end
    checks++; if (hi_o !== mhi || lo_o !== mlo) begin failures++; $display("[TB] FAIL mult_early_write got=%h_%h exp=%h_%h", hi_o, lo_o, mhi, mlo); end
    tick;
    drive_nop;
    {mhi, mlo} = exp;
    checks++; if ({hi_o, lo_o} !== exp) begin failures++; $display("[TB] FAIL mult_result %h*%h got=%h_%h exp=%h", a, b, hi_o, lo_o, exp); end
    checks++; if (mem_wreg_o !== 1'b0) begin failures++; $display("[TB] FAIL mult_done_wreg got=%b exp=0", mem_wreg_o); end
    tick;
  endtask

  task automatic test_mult;
    logic [31:0] a, b;
    run_mult(ALU_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    run_mult(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mult(ALU_MULT, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 2) a = 32'h8000_0000;
      run_mult((i % 2 == 0) ? ALU_MULT : ALU_MULTU, a, b);
    end
  endtask

  task automatic test_flush;
    int cnt;
    drive(ALU_OR, SEL_LOGIC, 32'h1, 32'h2, 5'd8, 1'b1);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    checks++; if (mem_wreg_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_alu_wreg got=%b exp=0", mem_wreg_o); end
    drive(ALU_MULT, SEL_NOP, 32'd7, 32'd9, 5'd9, 1'b0);
    tick;
    for (int i = 0; i < 10; i++) tick;
    checks++; if (stallreq_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy_stall got=%b exp=1", stallreq_o); end
    flush_i = 1'b1;
    #1;
    checks++; if (stallreq_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_cycle_stall got=%b exp=0", stallreq_o); end
    tick;
    flush_i = 1'b0;
    drive_nop;
    #1;
    checks++; if (stallreq_o !== 1'b0 || mem_wreg_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_after got=%b/%b exp=0/0", stallreq_o, mem_wreg_o); end
    for (int i = 0; i < 40; i++) tick;
    checks++; if (hi_o !== mhi || lo_o !== mlo) begin failures++; $display("[TB] FAIL flush_busy_hilo got=%h_%h exp=%h_%h", hi_o, lo_o, mhi, mlo); end
    drive(ALU_MULTU, SEL_NOP, 32'd5, 32'd5, 5'd9, 1'b0);
    #1;
    cnt = 0;
    while (stallreq_o === 1'b1 && cnt < 200) begin cnt++; tick; end
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    drive_nop;
    checks++; if (hi_o !== mhi || lo_o !== mlo) begin failures++; $display("[TB] FAIL flush_done_hilo got=%h_%h exp=%h_%h", hi_o, lo_o, mhi, mlo); end
    tick;
    run_mult(ALU_MULT, 32'hFFFF_FFF9, 32'd6);
  endtask

  task automatic test_rst_mid_mult;
    drive(ALU_MULT, SEL_NOP, 32'h0001_2345, 32'hFFFF_0003, 5'd9, 1'b1);
    tick;
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    drive_nop;
    tick;
    rst = 1'b0;
    mhi = '0; mlo = '0;
    checks++; if (mem_wreg_o !== 1'b0 || mem_wd_o !== 5'd0 || mem_wdata_o !== 32'd0) begin
      failures++; $display("[TB] FAIL rst_mid_mem got=%b/%0d/%h exp=0/0/0", mem_wreg_o, mem_wd_o, mem_wdata_o);
    end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_hilo got=%h_%h exp=0", hi_o, lo_o); end
    checks++; if (stallreq_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stall got=%b exp=0", stallreq_o); end
    for (int i = 0; i < 40; i++) tick;
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_late_hilo got=%h_%h exp=0", hi_o, lo_o); end
  endtask

  initial begin
    test_reset;
    test_or;
    test_shift;
    test_random_alu(40);
    test_hilo;
    test_mult;
    test_random_alu(20);
    test_flush;
    test_rst_mid_mult;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
